// File: rtl/fj_pkg.sv
// Shared types and helpers for the fork/join AND sequencer.
package fj_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN1 = 2'd1,
        RUN2 = 2'd2,
        HOLD = 2'd3
    } fj_state_t;

    localparam int FJ_LATENCY_DEF = 5;

    // Counter width able to hold LATENCY-1 down to 0 without wrap.
    function automatic int fj_cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/fj_and_lane.sv
// Registered bitwise AND; captures x&y on the load strobe, otherwise holds.
module fj_and_lane #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q_q <= '0;
        else if (ld_i) q_q <= x_i & y_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/fork_join_sched.sv
// Fork/join sequencer for the two-lane AND datapath (out1=a&b, out2=a&c).
// FJ_SERIAL_EN: evaluate both lanes on one shared AND unit, one lane per LATENCY window.
module fork_join_sched
    import fj_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int LATENCY = FJ_LATENCY_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [1:0]       lane_done,
    output logic             busy
);

    localparam int            CW       = fj_cnt_w(LATENCY);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    fj_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic             out_valid_q;
    logic [1:0]       lane_done_q;
    logic             accept, run1_exp, run2_exp, hold_exit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        run1_exp  = 1'b0;
        run2_exp  = 1'b0;
        hold_exit = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                accept  = 1'b1;
                cnt_d   = CNT_LOAD;
                state_d = RUN1;
            end
            RUN1: if (cnt_q == '0) begin
                run1_exp = 1'b1;
`ifdef FJ_SERIAL_EN
                cnt_d    = CNT_LOAD;
                state_d  = RUN2;
`else
                state_d  = HOLD;
`endif
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
`ifdef FJ_SERIAL_EN
            RUN2: if (cnt_q == '0) begin
                run2_exp = 1'b1;
                state_d  = HOLD;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
`endif
            HOLD: if (out_ready) begin
                hold_exit = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FJ_SERIAL_EN
    localparam logic LAST_LANE = 1'b1;
`else
    localparam logic LAST_LANE = 1'b0;
`endif

    // Join point: the final lane expiry raises out_valid.
    logic join_done;
    assign join_done = LAST_LANE ? run2_exp : run1_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            lane_done_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                a_q         <= a;
                b_q         <= b;
                c_q         <= c;
                lane_done_q <= 2'b00;
            end
            if (run1_exp) lane_done_q <= LAST_LANE ? 2'b01 : 2'b11;
            if (run2_exp) lane_done_q[1] <= 1'b1;
            if (join_done)      out_valid_q <= 1'b1;
            else if (hold_exit) out_valid_q <= 1'b0;
        end
    end

`ifdef FJ_SERIAL_EN
    // Shared unit: lane1 result on RUN1 expiry, lane2 on RUN2 expiry.
    // Lane1 is parked in out1_q when the unit is reused; out2 is meaningful once out_valid rises.
    logic [WIDTH-1:0] lane_q, out1_q;

    fj_and_lane #(.WIDTH(WIDTH)) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (run1_exp | run2_exp),
        .x_i   (a_q),
        .y_i   ((state_q == RUN2) ? c_q : b_q),
        .q_o   (lane_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        out1_q <= '0;
        else if (run2_exp) out1_q <= lane_q;
    end

    assign out1 = (state_q == RUN2) ? lane_q : out1_q;
    assign out2 = lane_q;
`else
    fj_and_lane #(.WIDTH(WIDTH)) u_lane1 (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (run1_exp),
        .x_i   (a_q),
        .y_i   (b_q),
        .q_o   (out1)
    );

    fj_and_lane #(.WIDTH(WIDTH)) u_lane2 (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (run1_exp),
        .x_i   (a_q),
        .y_i   (c_q),
        .q_o   (out2)
    );
`endif

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign lane_done = lane_done_q;

endmodule

// File: tb/tb_fork_join_sched.sv
// Directed bench for fork_join_sched (WIDTH=1, LATENCY=5); honours FJ_SERIAL_EN.
module tb_fork_join_sched;

    localparam int L = 5;
`ifdef FJ_SERIAL_EN
    localparam int JOIN_EDGES = 2 * L;
`else
    localparam int JOIN_EDGES = L;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0;
    logic       in_ready, out_valid, out1, out2, busy;
    logic [1:0] lane_done;

    int checks = 0;
    int errors = 0;

    fork_join_sched #(.WIDTH(1), .LATENCY(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1      (out1),
        .out2      (out2),
        .lane_done (lane_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand set; returns #1 after the accepting edge.
    task automatic offer(input logic va, input logic vb, input logic vc);
        a = va; b = vb; c = vc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out1, out2, busy, lane_done} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset: rdy/vld/o1/o2/busy/done=%b, want 1000000",
                     {in_ready, out_valid, out1, out2, busy, lane_done});
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        offer(1'b1, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept_state: busy=%b in_ready=%b, want 1 0", busy, in_ready);
        end
        for (int k = 1; k < JOIN_EDGES; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL early_valid: edge %0d out_valid=%b, want 0", k, out_valid);
            end
        end
        tick();
        checks++;
        if ({out_valid, out1, out2, lane_done} !== 5'b10111) begin
            errors++;
            $display("FAIL latency_join: vld/o1/o2/done=%b, want 10111",
                     {out_valid, out1, out2, lane_done});
        end
        drain();
    endtask

    task automatic test_input_churn();
        offer(1'b1, 1'b1, 1'b1);
        a = 1'b0; b = 1'b0; c = 1'b0;
        repeat (JOIN_EDGES) tick();
        checks++;
        if ({out_valid, out1, out2} !== 3'b111) begin
            errors++;
            $display("FAIL churn: vld/o1/o2=%b, want 111", {out_valid, out1, out2});
        end
        drain();
    endtask

    task automatic test_backpressure();
        offer(1'b1, 1'b1, 1'b0);
        repeat (JOIN_EDGES) tick();
        in_valid = 1'b1;
        a = 1'b1; b = 1'b0; c = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({out_valid, out1, out2, lane_done, in_ready, busy} !== 7'b1101101) begin
                errors++;
                $display("FAIL hold_stall: cyc %0d vld/o1/o2/done/rdy/busy=%b, want 1101101",
                         k, {out_valid, out1, out2, lane_done, in_ready, busy});
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL hold_exit: vld/rdy/busy=%b, want 010", {out_valid, in_ready, busy});
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL no_accept: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_abort();
        int seen;
        offer(1'b1, 1'b1, 1'b1);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL abort_reset: vld/busy/rdy=%b, want 001", {out_valid, busy, in_ready});
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (JOIN_EDGES + 2) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_ghost: %0d cycles with out_valid, want 0", seen);
        end
        offer(1'b1, 1'b1, 1'b0);
        repeat (JOIN_EDGES) tick();
        checks++;
        if ({out_valid, out1, out2} !== 3'b110) begin
            errors++;
            $display("FAIL abort_next: vld/o1/o2=%b, want 110", {out_valid, out1, out2});
        end
        drain();
    endtask

`ifdef FJ_SERIAL_EN
    task automatic test_serial();
        offer(1'b1, 1'b1, 1'b0);
        repeat (L) tick();
        checks++;
        if ({out_valid, out1, lane_done} !== 4'b0101) begin
            errors++;
            $display("FAIL serial_lane1: vld/o1/done=%b, want 0101", {out_valid, out1, lane_done});
        end
        repeat (L) tick();
        checks++;
        if ({out_valid, out1, out2, lane_done} !== 5'b11011) begin
            errors++;
            $display("FAIL serial_join: vld/o1/o2/done=%b, want 11011",
                     {out_valid, out1, out2, lane_done});
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_input_churn();
        test_backpressure();
        test_abort();
`ifdef FJ_SERIAL_EN
        test_serial();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
